// File: rtl/pinky_decode_stage.sv
// Decode/register-read stage: absorbs prefix words, builds op2, owns the register file.
// Define PINKY_DECODE_BYPASS_EN to forward same-cycle write-back data to register reads.
module pinky_decode_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NREGS      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_ir,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  wb_en,
    input  logic [3:0]            wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [6:0]            out_op_cc,
    output logic [3:0]            out_dest,
    output logic [DATA_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic                  pre_pending
);

    logic [DATA_WIDTH-1:0] rf_q [NREGS];
    logic [11:0]           prefix_q, prefix_d;
    logic                  pre_pending_q, pre_pending_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_rd_q, out_op2_q;
    logic [6:0]            out_op_cc_q;
    logic [3:0]            out_dest_q;

    logic                  accept, is_pre, load_bundle;
    logic [DATA_WIDTH-1:0] rd_val, op2_reg_val, op2_d;
    logic [15:0]           imm_ext;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready && !flush;
    assign is_pre      = (in_ir[15:14] == 2'b11);
    assign load_bundle = accept && !is_pre;

    // Unimplemented indices fall through the loop and read as zero.
    always_comb begin
        rd_val      = '0;
        op2_reg_val = '0;
        for (int i = 0; i < NREGS; i++) begin
`ifdef PINKY_DECODE_BYPASS_EN
            if (in_ir[7:4] == 4'(i)) begin
                rd_val = (wb_en && wb_dest == 4'(i)) ? wb_data : rf_q[i];
            end
            if (in_ir[3:0] == 4'(i)) begin
                op2_reg_val = (wb_en && wb_dest == 4'(i)) ? wb_data : rf_q[i];
            end
`else
            if (in_ir[7:4] == 4'(i)) rd_val = rf_q[i];
            if (in_ir[3:0] == 4'(i)) op2_reg_val = rf_q[i];
`endif
        end
    end

    always_comb begin
        imm_ext = {prefix_q, in_ir[3:0]};
        if (!in_ir[8]) begin
            op2_d = op2_reg_val;
        end else if (pre_pending_q) begin
            op2_d = DATA_WIDTH'($signed(imm_ext));
        end else begin
            op2_d = DATA_WIDTH'($signed(in_ir[3:0]));
        end
    end

    always_comb begin
        prefix_d      = prefix_q;
        pre_pending_d = pre_pending_q;
        out_valid_d   = out_valid_q;
        if (flush) begin
            out_valid_d   = 1'b0;
            pre_pending_d = 1'b0;
        end else if (accept && is_pre) begin
            // Accept implies the slot is empty or draining, so no bundle remains.
            prefix_d      = in_ir[11:0];
            pre_pending_d = 1'b1;
            out_valid_d   = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            if (in_ir[8]) pre_pending_d = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prefix_q      <= '0;
            pre_pending_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_op_cc_q   <= '0;
            out_dest_q    <= '0;
            out_rd_q      <= '0;
            out_op2_q     <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            prefix_q      <= prefix_d;
            pre_pending_q <= pre_pending_d;
            out_valid_q   <= out_valid_d;
            if (load_bundle) begin
                out_pc_q    <= in_pc;
                out_op_cc_q <= in_ir[15:9];
                out_dest_q  <= in_ir[7:4];
                out_rd_q    <= rd_val;
                out_op2_q   <= op2_d;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en && wb_dest == 4'(i)) rf_q[i] <= wb_data;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign pre_pending = pre_pending_q;
    assign out_pc      = out_pc_q;
    assign out_op_cc   = out_op_cc_q;
    assign out_dest    = out_dest_q;
    assign out_rd      = out_rd_q;
    assign out_op2     = out_op2_q;

endmodule

// File: tb/tb_pinky_decode_stage.sv
// Scoreboard bench for pinky_decode_stage: reference model pushes expected bundles,
// a negedge monitor compares whatever the DUT presents.
module tb_pinky_decode_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_ir = '0;
    logic [DW-1:0] in_pc = '0;
    logic          wb_en = 1'b0;
    logic [3:0]    wb_dest = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_pc;
    logic [6:0]    out_op_cc;
    logic [3:0]    out_dest;
    logic [DW-1:0] out_rd;
    logic [DW-1:0] out_op2;
    logic          pre_pending;

    pinky_decode_stage #(.DATA_WIDTH(DW), .NREGS(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ir      (in_ir),
        .in_pc      (in_pc),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_op_cc  (out_op_cc),
        .out_dest   (out_dest),
        .out_rd     (out_rd),
        .out_op2    (out_op2),
        .pre_pending(pre_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [6:0]    op_cc;
        logic [3:0]    dest;
        logic [DW-1:0] rd;
        logic [DW-1:0] op2;
    } bundle_t;

    bundle_t       exp_q[$];
    logic [DW-1:0] mrf [16];
    logic [11:0]   mpre;
    bit            mpend;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sext(input longint v, input int bits);
        longint s = v;
        if (v >= (longint'(1) << (bits - 1))) s = v - (longint'(1) << bits);
        return DW'(s);
    endfunction

    function automatic logic [DW-1:0] mread(input int idx);
        if (idx >= int'(NR)) return '0;
`ifdef PINKY_DECODE_BYPASS_EN
        if (wb_en && int'(wb_dest) == idx) return wb_data;
`endif
        return mrf[idx];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        mpend = 1'b0;
        mpre  = '0;
        for (int i = 0; i < 16; i++) mrf[i] = '0;
    endtask

    // Reference model: one-slot output buffer plus a pending-prefix latch.
    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (reset) begin
                bit            acc;
                logic [DW-1:0] rd, op2r;
                bundle_t       b;
                acc  = in_valid && (exp_q.size() == 0 || out_ready) && !flush;
                rd   = mread(int'(in_ir[7:4]));
                op2r = mread(int'(in_ir[3:0]));
                if (flush) begin
                    exp_q.delete();
                    mpend = 1'b0;
                end else if (acc && in_ir[15:14] == 2'b11) begin
                    mpre  = in_ir[11:0];
                    mpend = 1'b1;
                end else if (acc) begin
                    b.pc    = in_pc;
                    b.op_cc = in_ir[15:9];
                    b.dest  = in_ir[7:4];
                    b.rd    = rd;
                    if (!in_ir[8]) b.op2 = op2r;
                    else if (mpend) b.op2 = sext(longint'({mpre, in_ir[3:0]}), 16);
                    else b.op2 = sext(longint'(in_ir[3:0]), 4);
                    if (in_ir[8]) mpend = 1'b0;
                    exp_q.push_back(b);
                end
                if (wb_en && int'(wb_dest) < int'(NR)) mrf[wb_dest] = wb_data;
            end
        end
    end

    // Monitor: compares the presented bundle and handshake state mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                bundle_t b;
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0 || out_ready));
                chk("pre_pending", 64'(pre_pending), 64'(mpend));
                if (out_valid && exp_q.size() != 0) begin
                    b = exp_q[0];
                    chk("out_pc", 64'(out_pc), 64'(b.pc));
                    chk("out_op_cc", 64'(out_op_cc), 64'(b.op_cc));
                    chk("out_dest", 64'(out_dest), 64'(b.dest));
                    chk("out_rd", 64'(out_rd), 64'(b.rd));
                    chk("out_op2", 64'(out_op2), 64'(b.op2));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic reset_checks();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst pre_pending", 64'(pre_pending), 64'd0);
        chk("rst out_pc", 64'(out_pc), 64'd0);
        chk("rst out_op_cc", 64'(out_op_cc), 64'd0);
        chk("rst out_dest", 64'(out_dest), 64'd0);
        chk("rst out_rd", 64'(out_rd), 64'd0);
        chk("rst out_op2", 64'(out_op2), 64'd0);
    endtask

    task automatic drv(input bit v, input logic [15:0] ir, input bit fl, input bit ordy,
                       input bit we, input logic [3:0] wd, input logic [DW-1:0] wdat);
        in_valid  = v;
        in_ir     = ir;
        in_pc     = DW'($urandom);
        flush     = fl;
        out_ready = ordy;
        wb_en     = we;
        wb_dest   = wd;
        wb_data   = wdat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        reset_checks();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) drv(0, 16'h0000, 0, 1, 1, 4'(i), DW'($urandom));

        // Prefix then immediate ops, including a negative prefix.
        drv(1, 16'hCABC, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h0925, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h092A, 0, 1, 0, 4'd0, '0);
        drv(1, 16'hC800, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h0921, 0, 1, 0, 4'd0, '0);

        // Three-cycle stall with input offered throughout.
        drv(1, 16'h0812, 0, 1, 0, 4'd0, '0);
        repeat (3) drv(1, 16'h0834, 0, 0, 0, 4'd0, '0);
        drv(1, 16'h0834, 0, 1, 0, 4'd0, '0);

        // Same-cycle write-back to the register being read, then readback, then index 12.
        drv(1, 16'h1233, 0, 1, 1, 4'd3, DW'(32'h1234));
        drv(1, 16'h1233, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h10CC, 0, 1, 1, 4'd12, DW'(32'h5555));

        // Flush against a prefix and an instruction.
        drv(1, 16'hC123, 1, 1, 0, 4'd0, '0);
        drv(1, 16'h0925, 1, 1, 0, 4'd0, '0);
        drv(1, 16'h0925, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h0812, 0, 0, 0, 4'd0, '0);
        drv(1, 16'hC777, 1, 0, 0, 4'd0, '0);
        drv(0, 16'h0000, 0, 1, 0, 4'd0, '0);

        // Reset mid-stall with a prefix pending.
        drv(1, 16'hC456, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h0812, 0, 0, 0, 4'd0, '0);
        chk("pre-reset out_valid", 64'(out_valid), 64'd1);
        chk("pre-reset pre_pending", 64'(pre_pending), 64'd1);
        #2 reset = 1'b0;
        #1;
        reset_checks();
        model_clear();
        drv(1, 16'h0812, 0, 1, 0, 4'd0, '0);
        drv(1, 16'h0812, 0, 1, 0, 4'd0, '0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        drv(0, 16'h0000, 0, 1, 0, 4'd0, '0);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ir;
            ir = 16'($urandom);
            if ($urandom_range(0, 4) == 0) ir[15:14] = 2'b11;
            else if (ir[15:14] == 2'b11) ir[15] = 1'b0;
            drv($urandom_range(0, 9) < 8, ir, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                4'($urandom_range(0, 15)), DW'($urandom));
        end

        repeat (5) drv(0, 16'h0000, 0, 1, 0, 4'd0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
